// File: rtl/trig_readout_if.sv
// trig_readout_if: settings, ADC input and sequencer outputs of trig_readout_seq
// Ports (master = register block / bench side, slave = sequencer side):
//   enable, period[CW], delay[CW], nsamp[5], adc_data[DW]   master -> slave
//   ext_trig                                                 master -> slave, only with TRIG_EXT_EN
//   trig, acq, data_out, frame, busy, overrun_cnt[8]         slave -> master
interface trig_readout_if #(parameter int DW = 13, parameter int CW = 16);
  logic enable;
  logic [CW-1:0] period;
  logic [CW-1:0] delay;
  logic [4:0] nsamp;
  logic [DW-1:0] adc_data;
`ifdef TRIG_EXT_EN
  logic ext_trig;
`endif
  logic trig;
  logic acq;
  logic data_out;
  logic frame;
  logic busy;
  logic [7:0] overrun_cnt;
`ifdef TRIG_EXT_EN
  modport master (output enable, period, delay, nsamp, adc_data, ext_trig,
                  input trig, acq, data_out, frame, busy, overrun_cnt);
  modport slave (input enable, period, delay, nsamp, adc_data, ext_trig,
                 output trig, acq, data_out, frame, busy, overrun_cnt);
`else
  modport master (output enable, period, delay, nsamp, adc_data,
                  input trig, acq, data_out, frame, busy, overrun_cnt);
  modport slave (input enable, period, delay, nsamp, adc_data,
                 output trig, acq, data_out, frame, busy, overrun_cnt);
`endif
endinterface

// File: rtl/trig_readout_seq.sv
// trig_readout_seq: periodic trigger, delayed ADC capture window and framed serial readout
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    trig_readout_if.slave: enable/period/delay/nsamp/adc_data in,
//          trig/acq/data_out/frame/busy/overrun_cnt out (all registered)
// Macro TRIG_EXT_EN: triggers come from rising edges of bus.ext_trig instead of the period counter.
module trig_readout_seq #(
  parameter int DW = 13,
  parameter int DEPTH = 16,
  parameter int CW = 16
) (
  input logic clk,
  input logic rst_n,
  trig_readout_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(DW);
  typedef enum logic [1:0] {IDLE, DELAY, ACQ, SHIFT} state_t;
  state_t state, state_n;
  logic [CW-1:0] dly, dly_n;
  logic [AW-1:0] idx, idx_n, wi, wi_n, nm1, nm1_n;
  logic [BW-1:0] bi, bi_n;
  logic hdr, hdr_n;
  logic ev;
  logic [4:0] ns_c;
  logic trig_q, acq_q, frame_q, busy_q, data_q;
  logic [7:0] ovr_q;
  logic [DW-1:0] mem [DEPTH];
`ifdef TRIG_EXT_EN
  logic [2:0] sync;
  logic rise_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      rise_q <= 1'b0;
    end else begin
      sync <= {sync[1:0], bus.ext_trig};
      rise_q <= sync[1] & ~sync[2];
    end
  assign ev = bus.enable & rise_q;
`else
  logic en_q;
  logic [CW-1:0] cnt, per_m1;
  assign per_m1 = (bus.period < CW'(2)) ? CW'(1) : bus.period - CW'(1);
  // en_q delays the first count by one edge so the first trig lands a full period after enable is sampled
  assign ev = bus.enable & en_q & (cnt == per_m1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      en_q <= 1'b0;
      cnt <= '0;
    end else begin
      en_q <= bus.enable;
      cnt <= (ev | ~(bus.enable & en_q)) ? '0 : cnt + CW'(1);
    end
`endif
  assign ns_c = (bus.nsamp == 5'd0) ? 5'd1 : (bus.nsamp > 5'(DEPTH)) ? 5'(DEPTH) : bus.nsamp;
  always_comb begin
    state_n = state;
    dly_n = dly;
    idx_n = idx;
    wi_n = wi;
    bi_n = bi;
    hdr_n = hdr;
    nm1_n = nm1;
    case (state)
      IDLE: if (ev) begin
        state_n = DELAY;
        dly_n = bus.delay;
        nm1_n = AW'(ns_c - 5'd1);
      end
      // the trig cycle itself is the first DELAY cycle, giving delay+1 cycles to the first acq
      DELAY: if (dly == '0) begin
        state_n = ACQ;
        idx_n = '0;
      end else dly_n = dly - CW'(1);
      ACQ: if (idx == nm1) begin
        state_n = SHIFT;
        hdr_n = 1'b1;
        wi_n = '0;
        bi_n = BW'(DW - 1);
      end else idx_n = idx + AW'(1);
      SHIFT: if (hdr) hdr_n = 1'b0;
      else if (bi != '0) bi_n = bi - BW'(1);
      else if (wi == nm1) state_n = IDLE;
      else begin
        wi_n = wi + AW'(1);
        bi_n = BW'(DW - 1);
      end
      default: state_n = IDLE;
    endcase
  end
  // outputs are flops loaded from the next-state view so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      dly <= '0;
      idx <= '0;
      wi <= '0;
      bi <= '0;
      hdr <= 1'b0;
      nm1 <= '0;
      trig_q <= 1'b0;
      acq_q <= 1'b0;
      frame_q <= 1'b0;
      busy_q <= 1'b0;
      data_q <= 1'b0;
      ovr_q <= '0;
    end else begin
      state <= state_n;
      dly <= dly_n;
      idx <= idx_n;
      wi <= wi_n;
      bi <= bi_n;
      hdr <= hdr_n;
      nm1 <= nm1_n;
      trig_q <= ev & (state == IDLE);
      acq_q <= state_n == ACQ;
      frame_q <= state_n == SHIFT;
      busy_q <= state_n != IDLE;
      data_q <= (state_n == SHIFT) & (hdr_n | mem[wi_n][bi_n]);
      if (ev && state != IDLE && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
    end
  always_ff @(posedge clk)
    if (state == ACQ) mem[idx] <= bus.adc_data;
  assign bus.trig = trig_q;
  assign bus.acq = acq_q;
  assign bus.frame = frame_q;
  assign bus.busy = busy_q;
  assign bus.data_out = data_q;
  assign bus.overrun_cnt = ovr_q;
endmodule

// File: tb/tb_trig_readout_seq.sv
// tb_trig_readout_seq: table vectors, corner sequences and random runs checked against a timeline model
module tb_trig_readout_seq;
  localparam int DW = 13;
  localparam int DEPTH = 16;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  trig_readout_if #(.DW(DW), .CW(CW)) bus();
  trig_readout_seq #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef TRIG_EXT_EN
  initial bus.ext_trig = 1'b0;
`endif
  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  logic en_v = 1'b0;
  logic [CW-1:0] per_v = '0;
  logic [CW-1:0] dly_v = '0;
  logic [4:0] ns_v = '0;
  bit basic = 0;
  logic [DW-1:0] adc_hist [int];
  int run = 0;
  bit act = 0;
  int mT = 0, md = 0, mn = 0, movr = 0;
  typedef struct {
    int per; int dly; int ns; bit basic; int first; int aofs; int nacq; int flen; int gap;
  } vec_t;
  vec_t tbl [6];
  function automatic int peff(int p);
    return p < 2 ? 2 : p;
  endfunction
  function automatic int clampn(int n);
    return n == 0 ? 1 : (n > DEPTH ? DEPTH : n);
  endfunction
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, a, e);
    end
  endtask
  // one clock: drive this cycle's inputs, compare outputs with the timeline of the active sequence, advance the model
  task automatic step;
    logic [DW-1:0] a, w;
    int fs, len, o, b;
    bit eb, et, ea, ef, ed;
    @(posedge clk);
    cyc++;
    #1;
    a = DW'($urandom);
    if (basic && act && cyc == mT + md + 1) a = 13'h1ABC;
    else if (basic && act && cyc == mT + md + 2) a = 13'h0123;
    adc_hist[cyc] = a;
    bus.adc_data = a;
    bus.enable = en_v;
    bus.period = per_v;
    bus.delay = dly_v;
    bus.nsamp = ns_v;
    @(negedge clk);
    len = 2 + md + mn + mn * DW;
    fs = mT + md + mn + 1;
    eb = act && cyc < mT + len;
    et = act && cyc == mT;
    ea = act && cyc > mT + md && cyc <= mT + md + mn;
    ef = act && cyc >= fs && cyc <= fs + mn * DW;
    ed = 0;
    if (ef) begin
      o = cyc - fs;
      if (o == 0) ed = 1;
      else begin
        b = o - 1;
        w = adc_hist[mT + md + 1 + b / DW];
        ed = w[DW - 1 - b % DW];
      end
    end
    chk("trig", bus.trig, et);
    chk("busy", bus.busy, eb);
    chk("acq", bus.acq, ea);
    chk("frame", bus.frame, ef);
    chk("data_out", bus.data_out, ed);
    chk("overrun_cnt", bus.overrun_cnt, movr);
    run = en_v ? run + 1 : 0;
    if (en_v && run > 1 && (run - 1) % peff(int'(per_v)) == 0) begin
      if (!eb) begin
        act = 1;
        mT = cyc + 1;
        md = int'(dly_v);
        mn = clampn(int'(ns_v));
      end else if (movr < 255) movr++;
    end
  endtask
  task automatic do_reset;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    en_v = 1'b0;
    bus.enable = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_trig", bus.trig, 0);
    chk("rst_acq", bus.acq, 0);
    chk("rst_frame", bus.frame, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_ovr", bus.overrun_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run = 0;
    act = 0;
    movr = 0;
    basic = 0;
  endtask
  task automatic cfg(input int p, input int d, input int n);
    per_v = CW'(p);
    dly_v = CW'(d);
    ns_v = 5'(n);
  endtask
  initial begin
    logic [26:0] bits, exp_bits;
    int c0, tt, tt2, ta, na, fl, la, fst, t1, t2, cnt;
    bit done;
    exp_bits = {1'b1, 13'h1ABC, 13'h0123};
    bus.enable = 1'b0;
    bus.period = '0;
    bus.delay = '0;
    bus.nsamp = '0;
    bus.adc_data = '0;
    tbl[0] = '{200, 0, 2, 1, 200, 1, 2, 27, 200};
    tbl[1] = '{50, 5, 0, 0, 50, 6, 1, 14, 50};
    tbl[2] = '{300, 3, 31, 0, 300, 4, 16, 209, 300};
    tbl[3] = '{20, 1, 3, 0, 20, 2, 3, 40, 60};
    tbl[4] = '{1, 0, 1, 0, 2, 1, 1, 14, 18};
    tbl[5] = '{0, 2, 16, 0, 2, 3, 16, 209, 230};
    foreach (tbl[v]) begin
      do_reset;
      cfg(tbl[v].per, tbl[v].dly, tbl[v].ns);
      basic = tbl[v].basic;
      en_v = 1'b1;
      c0 = cyc + 1;
      tt = -1; ta = -1; na = 0; fl = 0; la = -1; fst = -1; bits = '0; done = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
        step;
        if (bus.trig && tt < 0) tt = cyc;
        if (tt >= 0 && fst < 0 && bus.acq) begin
          if (ta < 0) ta = cyc;
          na++;
          la = cyc;
        end
        if (tt >= 0 && bus.frame) begin
          if (fst < 0) fst = cyc;
          fl++;
          bits = {bits[25:0], bus.data_out};
        end else if (fst >= 0) done = 1;
      end
      chk("seq_done", done, 1);
      chk("first_trig", tt - (c0 + 1), tbl[v].first);
      chk("acq_offset", ta - tt, tbl[v].aofs);
      chk("acq_cycles", na, tbl[v].nacq);
      chk("frame_len", fl, tbl[v].flen);
      chk("frame_after_acq", fst, la + 1);
      if (tbl[v].basic) chk("frame_bits", bits, exp_bits);
      tt2 = -1;
      for (int i = 0; i < 600 && tt2 < 0; i++) begin
        step;
        if (bus.trig) tt2 = cyc;
      end
      chk("trig_gap", tt2 - tt, tbl[v].gap);
    end
    do_reset;
    cfg(10, 0, 4);
    en_v = 1'b1;
    t1 = -1; t2 = -1;
    for (int i = 0; i < 300 && t2 < 0; i++) begin
      step;
      if (bus.trig) begin
        if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end
    end
    chk("overrun_gap", t2 - t1, 60);
    chk("overrun_five", bus.overrun_cnt, 5);
    en_v = 1'b0;
    step;
    cfg(2, 0, 16);
    en_v = 1'b1;
    for (int i = 0; i < 900; i++) step;
    chk("overrun_sat", bus.overrun_cnt, 255);
    do_reset;
    cfg(31, 0, 2);
    en_v = 1'b1;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step;
      if (bus.trig) cnt++;
    end
    chk("b2b_trigs", cnt, 6);
    chk("b2b_ovr", bus.overrun_cnt, 0);
    do_reset;
    cfg(100, 0, 4);
    en_v = 1'b1;
    fl = 0;
    for (int i = 0; i < 300 && fl == 0; i++) begin
      step;
      if (bus.frame) fl = 1;
    end
    en_v = 1'b0;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      step;
      if (bus.frame) fl++;
      if (bus.trig) cnt++;
    end
    chk("drop_frame_len", fl, 53);
    chk("drop_no_trig", cnt, 0);
    do_reset;
    cfg(30, 3, 8);
    en_v = 1'b1;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      step;
      if (bus.acq) done = 1;
    end
    chk("reach_acq", done, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_trig", bus.trig, 0);
    chk("arst_acq", bus.acq, 0);
    chk("arst_frame", bus.frame, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_data", bus.data_out, 0);
    chk("arst_ovr", bus.overrun_cnt, 0);
    do_reset;
    en_v = 1'b1;
    c0 = cyc + 1;
    tt = -1;
    for (int i = 0; i < 100 && tt < 0; i++) begin
      step;
      if (bus.trig) tt = cyc;
    end
    chk("post_rst_trig", tt - (c0 + 1), 30);
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 7) == 0) do_reset;
      en_v = 1'b0;
      step;
      case ($urandom_range(0, 5))
        0: per_v = '0;
        1: per_v = CW'(1);
        default: per_v = CW'($urandom_range(2, 150));
      endcase
      en_v = 1'b1;
      for (int k = 0, n = $urandom_range(50, 400); k < n; k++) begin
        dly_v = CW'($urandom_range(0, 12));
        ns_v = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 63) == 0) en_v = ~en_v;
        step;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
